// File: rtl/fifo_pkg.sv
// Shared types and constants for the round-robin FIFO controller.
// Holds the occupancy-state enum and the default FIFO depth (as log2).
package fifo_pkg;

  // Default log2 of the FIFO depth (8 entries)
  localparam int FIFO_DEPTH_LOG2 = 3;

  // Occupancy state of the FIFO
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_state_t;

endpackage : fifo_pkg

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter (purely combinational).
// On a tie the requester that was not granted most recently wins;
// rr_last = 0 means A was granted last, 1 means B was granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       rr_last,
  output logic [1:0] gnt
);

  // One-hot grant selection; nothing is granted while disabled
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule : rr_arb2

// File: rtl/fifo_rr_ctrl.sv
// FIFO controller with two round-robin arbitrated writers and one reader.
// Generates RAM strobes and wrap-bit pointers; occupancy is tracked by an
// EMPTY/PARTIAL/FULL state machine. No fall-through: a read is refused in
// EMPTY and a write is refused in FULL, even if the other side is accepted.
// Optional feature: define FIFO_RR_ERR_FLAG_EN to add the sticky 'err'
// output, set after any request refused for overflow/underflow.
module fifo_rr_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            wr_req,
  input  logic                  rd_req,
  output logic [1:0]            wr_grant,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [DEPTH_LOG2:0]   Write_Ptr,
  output logic [DEPTH_LOG2:0]   Read_Ptr,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic [DEPTH_LOG2:0]   count
`ifdef FIFO_RR_ERR_FLAG_EN
  ,
  output logic                  err
`endif
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] C_ONE  = PW'(1);
  localparam logic [PW-1:0] C_LAST = PW'((1 << DEPTH_LOG2) - 1);

  occ_state_t     r_state;
  occ_state_t     w_state_next;
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [PW-1:0]  w_count;
  logic           r_rr_last;
  logic           w_wr_ok;
  logic           w_rd_acc;
  logic           w_wr_acc;
  logic [1:0]     w_grant;

  // Accept conditions; reset masks every strobe in the same cycle
  assign w_wr_ok  = !reset && (r_state != FULL);
  assign w_rd_acc = !reset && rd_req && (r_state != EMPTY);

  rr_arb2 u_arb (
    .req     (wr_req),
    .enable  (w_wr_ok),
    .rr_last (r_rr_last),
    .gnt     (w_grant)
  );

  assign w_wr_acc = |w_grant;
  assign w_count  = r_wptr - r_rptr;

  assign wr_grant   = w_grant;
  assign wr_en      = w_wr_acc;
  assign rd_en      = w_rd_acc;
  assign Write_Ptr  = r_wptr;
  assign Read_Ptr   = r_rptr;
  assign count      = w_count;
  assign fifo_full  = (r_state == FULL);
  assign fifo_empty = (r_state == EMPTY);

  // Occupancy state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next occupancy state; simultaneous read+write leaves the state unchanged
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      EMPTY: begin
        if (w_wr_acc && !w_rd_acc) w_state_next = PARTIAL;
      end
      PARTIAL: begin
        if (w_wr_acc && !w_rd_acc && (w_count == C_LAST)) w_state_next = FULL;
        else if (w_rd_acc && !w_wr_acc && (w_count == C_ONE)) w_state_next = EMPTY;
      end
      FULL: begin
        if (w_rd_acc && !w_wr_acc) w_state_next = PARTIAL;
      end
      default: w_state_next = EMPTY;
    endcase
  end

  // Pointer advance and round-robin history (updated only on accepted writes)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_rr_last <= 1'b1;
    end else begin
      if (w_wr_acc) begin
        r_wptr    <= r_wptr + C_ONE;
        r_rr_last <= w_grant[1];
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + C_ONE;
      end
    end
  end

`ifdef FIFO_RR_ERR_FLAG_EN
  logic r_err;
  logic w_refused;

  assign w_refused = ((|wr_req) && (r_state == FULL)) ||
                     (rd_req && (r_state == EMPTY));
  assign err = r_err;

  // Sticky overflow/underflow flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_refused) begin
      r_err <= 1'b1;
    end
  end
`endif

endmodule : fifo_rr_ctrl
